until_req_driver: RTL and testbench

- Initiator side of the "req until ack" handshake that the team's assertion checkers monitor.
- Raises `req` with latched data and holds both stable until `ack` is sampled.
- An optional timeout gives the strong-until guarantee: `req` can never stay high forever.
- Reports completion or timeout, plus the measured hold length, to the controlling logic.

---
 rtl/until_req_driver_if.sv | 27 ++
 rtl/until_req_driver.sv | 87 ++++++++
 tb/tb_until_req_driver.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/until_req_driver_if.sv
// until_req_driver_if: bundle for the req-until-ack initiator.
// Signals: start/start_data/ack in; req/req_data/busy/done/timeout/hold_cnt out.
// master = the driver itself; slave = controlling logic plus responder.
interface until_req_driver_if #(
   parameter int DW = 8,
   parameter int CW = 8
);
   logic          start;
   logic [DW-1:0] start_data;
   logic          ack;
   logic          req;
   logic [DW-1:0] req_data;
   logic          busy;
   logic          done;
   logic          timeout;
   logic [CW-1:0] hold_cnt;

   modport master (
      input  start, start_data, ack,
      output req, req_data, busy, done, timeout, hold_cnt
   );

   modport slave (
      output start, start_data, ack,
      input  req, req_data, busy, done, timeout, hold_cnt
   );
endinterface

// File: rtl/until_req_driver.sv
// until_req_driver: raises req with latched data and holds it until ack,
// or until TIMEOUT req-high cycles (0 = hold forever). Reports done/timeout.
// Ports: clk, rst (sync, active-low), bus (until_req_driver_if.master).
module until_req_driver #(
   parameter int DW      = 8,
   parameter int TIMEOUT = 16,
   parameter int CW      = 8
) (
   input  logic               clk,
   input  logic               rst,
   until_req_driver_if.master bus
);
   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_e;

   localparam logic [CW-1:0] TO_V    = CW'(TIMEOUT);
   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
   localparam bit            TO_EN   = (TIMEOUT != 0);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] hold_cnt_q, hold_cnt_d;
   logic [DW-1:0] req_data_q, req_data_d;
   logic          done_q, done_d;
   logic          timeout_q, timeout_d;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      hold_cnt_d = hold_cnt_q;
      req_data_d = req_data_q;
      done_d     = 1'b0;
      timeout_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               req_data_d = bus.start_data;
               cnt_d      = CW'(1);
               state_d    = HOLD;
            end
         end
         HOLD: begin
            // ack is checked first so it wins over a coincident timeout
            if (bus.ack) begin
               done_d     = 1'b1;
               hold_cnt_d = cnt_q;
               state_d    = IDLE;
            end else if (TO_EN && (cnt_q == TO_V)) begin
               timeout_d  = 1'b1;
               hold_cnt_d = cnt_q;
               state_d    = IDLE;
            end else if (cnt_q != CNT_MAX) begin
               // saturate so a weak-mode hold never wraps the count
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         hold_cnt_q <= '0;
         req_data_q <= '0;
         done_q     <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         hold_cnt_q <= hold_cnt_d;
         req_data_q <= req_data_d;
         done_q     <= done_d;
         timeout_q  <= timeout_d;
      end
   end

   assign bus.req      = (state_q == HOLD);
   assign bus.busy     = (state_q == HOLD);
   assign bus.req_data = req_data_q;
   assign bus.done     = done_q;
   assign bus.timeout  = timeout_q;
   assign bus.hold_cnt = hold_cnt_q;
endmodule

// File: tb/tb_until_req_driver.sv
// tb_until_req_driver: three DUTs (TIMEOUT 16, 0, 4) driven by transactions;
// a negedge monitor pops expected outcomes from per-DUT queues.
module tb_until_req_driver;
   localparam int DW    = 8;
   localparam int CW    = 8;
   localparam int NI    = 3;
   localparam int NEVER = 100000;
   localparam int SAT   = (1 << CW) - 1;

   typedef struct {
      logic          is_to;
      int            hold;
      int            len;
      logic [DW-1:0] data;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [NI-1:0] start_v;
   logic [NI-1:0] ack_v;
   logic [DW-1:0] sd_v [NI];
   logic [NI-1:0] req_v;
   logic [NI-1:0] busy_v;
   logic [NI-1:0] done_v;
   logic [NI-1:0] to_v;
   logic [DW-1:0] rd_v [NI];
   logic [CW-1:0] hc_v [NI];

   int   n_cmp = 0;
   int   n_err = 0;
   exp_t q [NI][$];
   int   run [NI];
   int   to_of [NI] = '{16, 0, 4};

   always #5 clk = ~clk;

   for (genvar k = 0; k < NI; k++) begin : g_dut
      until_req_driver_if #(.DW(DW), .CW(CW)) bus ();
      assign bus.start      = start_v[k];
      assign bus.start_data = sd_v[k];
      assign bus.ack        = ack_v[k];
      assign req_v[k]       = bus.req;
      assign busy_v[k]      = bus.busy;
      assign done_v[k]      = bus.done;
      assign to_v[k]        = bus.timeout;
      assign rd_v[k]        = bus.req_data;
      assign hc_v[k]        = bus.hold_cnt;
      until_req_driver #(
         .DW(DW),
         .TIMEOUT(k == 0 ? 16 : (k == 1 ? 0 : 4)),
         .CW(CW)
      ) dut (
         .clk(clk),
         .rst(rst),
         .bus(bus)
      );
   end

   task automatic chk(string name, int act, int want);
      n_cmp++;
      if (act != want) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d at %0t",
                  name, act, want, $time);
      end
   endtask

   // Outcome of one request from the handshake rules alone:
   // ack on req-high cycle n finishes it unless the timeout expires first.
   function automatic exp_t predict(int tv, int n, logic [DW-1:0] d);
      exp_t e;
      e.data = d;
      if (tv != 0 && n > tv) begin
         e.is_to = 1'b1;
         e.len   = tv;
         e.hold  = tv;
      end else begin
         e.is_to = 1'b0;
         e.len   = n;
         e.hold  = (n > SAT) ? SAT : n;
      end
      return e;
   endfunction

   always @(negedge clk) begin : mon
      exp_t e;
      for (int k = 0; k < NI; k++) begin
         if (!rst) begin
            run[k] = 0;
         end else begin
            chk("busy_eq_req", int'(busy_v[k]), int'(req_v[k]));
            if (req_v[k]) begin
               run[k]++;
               chk("req_expected", int'(q[k].size() != 0), 1);
               if (q[k].size() != 0)
                  chk("req_data_hold", int'(rd_v[k]), int'(q[k][0].data));
            end else if (run[k] != 0) begin
               chk("req_fall_pulse", int'(done_v[k] | to_v[k]), 1);
            end
            if (done_v[k] || to_v[k]) begin
               chk("pulse_expected", int'(q[k].size() != 0), 1);
               if (q[k].size() != 0) begin
                  e = q[k].pop_front();
                  chk("done", int'(done_v[k]), int'(!e.is_to));
                  chk("timeout", int'(to_v[k]), int'(e.is_to));
                  chk("hold_cnt", int'(hc_v[k]), e.hold);
                  chk("req_data_end", int'(rd_v[k]), int'(e.data));
                  chk("req_high_len", run[k], e.len);
                  chk("req_low_pulse", int'(req_v[k]), 0);
               end
               run[k] = 0;
            end
         end
      end
   end

   task automatic txn(int k, logic [DW-1:0] d, int n, bit b2b, bit noise);
      exp_t e;
      e = predict(to_of[k], n, d);
      q[k].push_back(e);
      start_v[k] = 1'b1;
      sd_v[k]    = d;
      @(posedge clk); #1;
      start_v[k] = 1'b0;
      sd_v[k]    = DW'($urandom);
      chk("start_req", int'(req_v[k]), 1);
      chk("start_data", int'(rd_v[k]), int'(d));
      for (int i = 1; i <= e.len; i++) begin
         ack_v[k] = (i == n);
         if (noise && i != n && $urandom_range(0, 1) == 0) begin
            start_v[k] = 1'b1;
            sd_v[k]    = DW'($urandom);
         end
         @(posedge clk); #1;
         ack_v[k]   = 1'b0;
         start_v[k] = 1'b0;
      end
      if (!b2b) begin
         int gap;
         gap = $urandom_range(1, 3);
         repeat (gap) begin
            ack_v[k] = noise ? 1'($urandom) : 1'b0;
            sd_v[k]  = DW'($urandom);
            @(posedge clk); #1;
         end
         ack_v[k] = 1'b0;
      end
   endtask

   task automatic chk_zero();
      for (int k = 0; k < NI; k++) begin
         chk("rst_req", int'(req_v[k]), 0);
         chk("rst_done", int'(done_v[k]), 0);
         chk("rst_timeout", int'(to_v[k]), 0);
         chk("rst_hold_cnt", int'(hc_v[k]), 0);
         chk("rst_req_data", int'(rd_v[k]), 0);
      end
   endtask

   task automatic rst_txn(int k, logic [DW-1:0] d);
      q[k].push_back(predict(to_of[k], NEVER, d));
      start_v[k] = 1'b1;
      sd_v[k]    = d;
      @(posedge clk); #1;
      start_v[k] = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
      end
      chk("pre_rst_req", int'(req_v[k]), 1);
      rst = 1'b0;
      @(posedge clk); #1;
      chk_zero();
      q[k].delete();
      rst = 1'b1;
   endtask

   initial begin
      rst     = 1'b0;
      start_v = '0;
      ack_v   = '0;
      for (int k = 0; k < NI; k++) sd_v[k] = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_zero();
      rst = 1'b1;
      @(posedge clk); #1;

      txn(0, 8'hA5, 3, 1'b1, 1'b0);
      txn(0, 8'h3C, 5, 1'b0, 1'b0);
      txn(0, 8'h11, NEVER, 1'b0, 1'b0);

      ack_v[2] = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
      end
      ack_v[2] = 1'b0;
      chk("idle_ack_req", int'(req_v[2]), 0);
      chk("idle_ack_done", int'(done_v[2]), 0);
      txn(2, 8'h22, 4, 1'b0, 1'b1);
      txn(2, 8'h33, NEVER, 1'b0, 1'b1);

      txn(1, 8'h44, 300, 1'b0, 1'b1);
      txn(1, 8'h45, 2, 1'b0, 1'b1);

      rst_txn(0, 8'h55);
      txn(0, 8'h66, 2, 1'b0, 1'b1);

      for (int t = 0; t < 60; t++) begin
         int k;
         int n;
         int tv;
         k  = $urandom_range(0, NI - 1);
         tv = to_of[k];
         if (tv == 0)
            n = ($urandom_range(0, 5) == 0) ? $urandom_range(250, 300)
                                            : $urandom_range(1, 20);
         else
            n = ($urandom_range(0, 3) == 0) ? NEVER
                                            : $urandom_range(1, tv + 2);
         txn(k, DW'($urandom), n, 1'($urandom), 1'b1);
      end

      repeat (5) begin
         @(posedge clk); #1;
      end
      for (int k = 0; k < NI; k++)
         chk("queue_drained", q[k].size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end
endmodule
